// File: rtl/conv_window_scheduler_if.sv
// Handshake and RAM-address bundle between the layer controller, the window
// scheduler, the weight/feature RAMs and the MAC array.
interface conv_window_scheduler_if #(
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 6
);
  logic              start;
  logic [2:0]        kernel_size;
  logic [DIM_W-1:0]  img_width;
  logic [DIM_W-1:0]  img_height;
  logic [ADDR_W-1:0] feat_base;
  logic              mac_ready;
  logic [5:0]        addr_RAM_weight;
  logic              read_RAM_weight;
  logic [ADDR_W-1:0] addr_RAM_feat;
  logic              read_RAM_feat;
  logic              win_first;
  logic              win_last;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, kernel_size, img_width, img_height, feat_base, mac_ready,
    input  addr_RAM_weight, read_RAM_weight, addr_RAM_feat, read_RAM_feat,
    input  win_first, win_last, busy, done, err
  );

  modport slave (
    input  start, kernel_size, img_width, img_height, feat_base, mac_ready,
    output addr_RAM_weight, read_RAM_weight, addr_RAM_feat, read_RAM_feat,
    output win_first, win_last, busy, done, err
  );
endinterface

// File: rtl/conv_window_scheduler.sv
// Convolution window scheduler: walks output pixels and kernel taps, issuing paired
// weight/feature RAM reads. Define CONV_PAD_EN to build with "same" zero padding.
module conv_window_scheduler #(
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 6
) (
  input logic                    clk,
  input logic                    rst,
  conv_window_scheduler_if.slave bus
);
  localparam int DW1 = DIM_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [DIM_W-1:0]  w_q, w_d, h_q, h_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        kx_q, kx_d, ky_q, ky_d;
  logic [DIM_W-1:0]  ox_q, ox_d, oy_q, oy_d;
  logic              last_q, last_d;
  logic [5:0]        addr_w_q, addr_w_d;
  logic [ADDR_W-1:0] addr_f_q, addr_f_d;
  logic              rd_w_q, rd_w_d, rd_f_q, rd_f_d;
  logic              wf_q, wf_d, wl_q, wl_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [DIM_W-1:0]  k_ext, ow, oh;
  logic [2:0]        k_m1;
  logic [DW1-1:0]    row_raw, col_raw, row, col;
  logic              cfg_ok, tap_in, issue;
  logic              kx_end, ky_end, ox_end, oy_end;

  function automatic logic [ADDR_W-1:0] feat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [DW1-1:0]    r,
                                                  input logic [DW1-1:0]    c,
                                                  input logic [DIM_W-1:0]  width);
    feat_addr = base + ADDR_W'(r) * ADDR_W'(width) + ADDR_W'(c);
  endfunction

  function automatic logic [5:0] weight_addr(input logic [2:0] ky, input logic [2:0] kx,
                                             input logic [2:0] k);
    weight_addr = 6'(ky) * 6'(k) + 6'(kx);
  endfunction

  assign k_ext   = DIM_W'(k_q);
  assign k_m1    = k_q - 3'd1;
  assign row_raw = {1'b0, oy_q} + DW1'(ky_q);
  assign col_raw = {1'b0, ox_q} + DW1'(kx_q);

`ifdef CONV_PAD_EN
  logic [1:0] pad;
  assign pad    = k_q[2:1];
  assign row    = row_raw - DW1'(pad);
  assign col    = col_raw - DW1'(pad);
  // Coordinates are shifted by P; anything that went negative or past the edge is a pad tap.
  assign tap_in = (row_raw >= DW1'(pad)) && (col_raw >= DW1'(pad)) &&
                  (row < {1'b0, h_q}) && (col < {1'b0, w_q});
  assign ow     = w_q;
  assign oh     = h_q;
  assign cfg_ok = (k_q != 3'd0) && k_q[0] && (k_ext <= w_q) && (k_ext <= h_q);
`else
  assign row    = row_raw;
  assign col    = col_raw;
  assign tap_in = 1'b1;
  assign ow     = w_q - k_ext + DIM_W'(1);
  assign oh     = h_q - k_ext + DIM_W'(1);
  assign cfg_ok = (k_q != 3'd0) && (k_ext <= w_q) && (k_ext <= h_q);
`endif

  assign kx_end = (kx_q == k_m1);
  assign ky_end = (ky_q == k_m1);
  assign ox_end = (ox_q == ow - DIM_W'(1));
  assign oy_end = (oy_q == oh - DIM_W'(1));

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    w_d      = w_q;
    h_d      = h_q;
    base_d   = base_q;
    kx_d     = kx_q;
    ky_d     = ky_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    last_d   = last_q;
    addr_w_d = addr_w_q;
    addr_f_d = addr_f_q;
    rd_w_d   = 1'b0;
    rd_f_d   = 1'b0;
    wf_d     = 1'b0;
    wl_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    issue    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          k_d     = bus.kernel_size;
          w_d     = bus.img_width;
          h_d     = bus.img_height;
          base_d  = bus.feat_base;
          kx_d    = 3'd0;
          ky_d    = 3'd0;
          ox_d    = '0;
          oy_d    = '0;
          last_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!cfg_ok) begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          // Tap (0,0) may already be taken here so it appears two cycles after start.
          state_d = S_RUN;
          issue   = bus.mac_ready;
        end
      end
      S_RUN: begin
        if (last_q) begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          issue = bus.mac_ready;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      rd_w_d   = 1'b1;
      rd_f_d   = tap_in;
      addr_w_d = weight_addr(ky_q, kx_q, k_q);
      addr_f_d = tap_in ? feat_addr(base_q, row, col, w_q) : '0;
      wf_d     = (kx_q == 3'd0) && (ky_q == 3'd0);
      wl_d     = kx_end && ky_end;
      if (!kx_end) begin
        kx_d = kx_q + 3'd1;
      end else begin
        kx_d = 3'd0;
        if (!ky_end) begin
          ky_d = ky_q + 3'd1;
        end else begin
          ky_d = 3'd0;
          if (!ox_end) begin
            ox_d = ox_q + DIM_W'(1);
          end else begin
            ox_d = '0;
            if (!oy_end) begin
              oy_d = oy_q + DIM_W'(1);
            end else begin
              oy_d   = '0;
              last_d = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      kx_q     <= 3'd0;
      ky_q     <= 3'd0;
      ox_q     <= '0;
      oy_q     <= '0;
      last_q   <= 1'b0;
      addr_w_q <= '0;
      addr_f_q <= '0;
      rd_w_q   <= 1'b0;
      rd_f_q   <= 1'b0;
      wf_q     <= 1'b0;
      wl_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      kx_q     <= kx_d;
      ky_q     <= ky_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      last_q   <= last_d;
      addr_w_q <= addr_w_d;
      addr_f_q <= addr_f_d;
      rd_w_q   <= rd_w_d;
      rd_f_q   <= rd_f_d;
      wf_q     <= wf_d;
      wl_q     <= wl_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Latched layer configuration only matters between start and done.
  always_ff @(posedge clk) begin
    k_q    <= k_d;
    w_q    <= w_d;
    h_q    <= h_d;
    base_q <= base_d;
  end

  assign bus.addr_RAM_weight = addr_w_q;
  assign bus.read_RAM_weight = rd_w_q;
  assign bus.addr_RAM_feat   = addr_f_q;
  assign bus.read_RAM_feat   = rd_f_q;
  assign bus.win_first       = wf_q;
  assign bus.win_last        = wl_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.err             = err_q;
endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench for conv_window_scheduler: fixed layer configurations with
// hand-derived tap counts, addresses and done timing.
module tb_conv_window_scheduler;
  localparam int ADDR_W = 12;
  localparam int DIM_W  = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_scheduler_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();

  conv_window_scheduler #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int a;
    int fr;
    int wa;
    int wf;
    int wl;
  } tap_t;

  int n_checks = 0;
  int n_fail   = 0;
  int rec_addr [16];
  int rec_fr   [16];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Runs one pass starting next cycle (start = cycle 0) and observes the outputs each cycle.
  task automatic run_pass(input int k, input int w, input int h, input int base,
                          input int stall_c0, input int stall_len, input int poke_c,
                          input int abort_tap,
                          output int taps, output int done_c, output int err_v,
                          output int wf_n, output int hold_bad, output int stream_bad,
                          output int busy1, output int busy_dn);
    tap_t exp_q[$];
    tap_t t;
    int p, ow, oh, r, cc, prev_a, prev_mr, got_a;
    p  = 0;
    ow = w - k + 1;
    oh = h - k + 1;
`ifdef CONV_PAD_EN
    p  = k / 2;
    ow = w;
    oh = h;
`endif
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            r    = oy + ky - p;
            cc   = ox + kx - p;
            t.fr = (r >= 0 && r < h && cc >= 0 && cc < w) ? 1 : 0;
            t.a  = t.fr ? ((base + r * w + cc) % 4096) : 0;
            t.wa = ky * k + kx;
            t.wf = (kx == 0 && ky == 0) ? 1 : 0;
            t.wl = (kx == k - 1 && ky == k - 1) ? 1 : 0;
            exp_q.push_back(t);
          end

    taps = 0; done_c = -1; err_v = 0; wf_n = 0; hold_bad = 0; stream_bad = 0;
    busy1 = 0; busy_dn = -1; prev_a = 0; prev_mr = 1;

    @(posedge clk); #1;
    bus.start       = 1'b1;
    bus.kernel_size = 3'(k);
    bus.img_width   = 6'(w);
    bus.img_height  = 6'(h);
    bus.feat_base   = 12'(base);
    bus.mac_ready   = 1'b1;

    for (int c = 1; c < 400; c++) begin
      @(posedge clk); #1;
      bus.start       = (c == poke_c);
      bus.kernel_size = 3'd1;
      bus.img_width   = 6'd9;
      bus.img_height  = 6'd2;
      bus.feat_base   = 12'hABC;
      prev_mr         = int'(bus.mac_ready);
      bus.mac_ready   = !(c >= stall_c0 && c < stall_c0 + stall_len);
      @(negedge clk);
      if (c == 1) busy1 = int'(bus.busy);
      got_a = int'(bus.addr_RAM_feat);
      if (bus.read_RAM_weight) begin
        if (prev_mr == 0) hold_bad++;
        if (taps < exp_q.size()) begin
          t = exp_q[taps];
          if (got_a != t.a || int'(bus.read_RAM_feat) != t.fr ||
              int'(bus.addr_RAM_weight) != t.wa || int'(bus.win_first) != t.wf ||
              int'(bus.win_last) != t.wl)
            stream_bad++;
        end else begin
          stream_bad++;
        end
        if (taps < 16) begin
          rec_addr[taps] = got_a;
          rec_fr[taps]   = int'(bus.read_RAM_feat);
        end
        taps++;
        wf_n += int'(bus.win_first);
      end else begin
        if (bus.read_RAM_feat) stream_bad++;
        if (taps > 0 && !bus.done && got_a != prev_a) hold_bad++;
      end
      prev_a = got_a;
      if (bus.done) begin
        done_c  = c;
        err_v   = int'(bus.err);
        busy_dn = int'(bus.busy);
        break;
      end
      if (abort_tap > 0 && taps == abort_tap) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int taps, done_c, err_v, wf_n, hold_bad, stream_bad, busy1, busy_dn;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.kernel_size = 3'd0;
    bus.img_width   = 6'd0;
    bus.img_height  = 6'd0;
    bus.feat_base   = 12'd0;
    bus.mac_ready   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy",   int'(bus.busy), 0);
    check_eq("rst_done",   int'(bus.done), 0);
    check_eq("rst_err",    int'(bus.err), 0);
    check_eq("rst_rd_w",   int'(bus.read_RAM_weight), 0);
    check_eq("rst_addr_f", int'(bus.addr_RAM_feat), 0);
    @(posedge clk); #1;
    rst = 1'b0;

`ifndef CONV_PAD_EN
    run_pass(3, 5, 5, 'h100, 1000, 0, -1, 0,
             taps, done_c, err_v, wf_n, hold_bad, stream_bad, busy1, busy_dn);
    check_eq("p1_busy_c1",   busy1, 1);
    check_eq("p1_taps",      taps, 81);
    check_eq("p1_done_c",    done_c, 83);
    check_eq("p1_err",       err_v, 0);
    check_eq("p1_busy_done", busy_dn, 0);
    check_eq("p1_windows",   wf_n, 9);
    check_eq("p1_stream",    stream_bad, 0);
    check_eq("p1_a0",        rec_addr[0], 'h100);
    check_eq("p1_a2",        rec_addr[2], 'h102);
    check_eq("p1_a3",        rec_addr[3], 'h105);
    check_eq("p1_a8",        rec_addr[8], 'h10C);
    check_eq("p1_win1_a0",   rec_addr[9], 'h101);

    run_pass(3, 5, 5, 'h100, 11, 4, -1, 0,
             taps, done_c, err_v, wf_n, hold_bad, stream_bad, busy1, busy_dn);
    check_eq("stall_taps",   taps, 81);
    check_eq("stall_done_c", done_c, 87);
    check_eq("stall_hold",   hold_bad, 0);
    check_eq("stall_stream", stream_bad, 0);

    run_pass(3, 5, 5, 'h100, 1000, 0, 30, 0,
             taps, done_c, err_v, wf_n, hold_bad, stream_bad, busy1, busy_dn);
    check_eq("poke_taps",   taps, 81);
    check_eq("poke_done_c", done_c, 83);
    check_eq("poke_stream", stream_bad, 0);

    run_pass(3, 5, 5, 'h100, 1000, 0, -1, 40,
             taps, done_c, err_v, wf_n, hold_bad, stream_bad, busy1, busy_dn);
    check_eq("abort_taps", taps, 40);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_busy",   int'(bus.busy), 0);
    check_eq("abort_done",   int'(bus.done), 0);
    check_eq("abort_rd_w",   int'(bus.read_RAM_weight), 0);
    check_eq("abort_addr_f", int'(bus.addr_RAM_feat), 0);
    check_eq("abort_addr_w", int'(bus.addr_RAM_weight), 0);
    run_pass(3, 5, 5, 'h200, 1000, 0, -1, 0,
             taps, done_c, err_v, wf_n, hold_bad, stream_bad, busy1, busy_dn);
    check_eq("restart_a0",     rec_addr[0], 'h200);
    check_eq("restart_taps",   taps, 81);
    check_eq("restart_done_c", done_c, 83);
    check_eq("restart_stream", stream_bad, 0);
`else
    run_pass(3, 4, 4, 'h200, 1000, 0, -1, 0,
             taps, done_c, err_v, wf_n, hold_bad, stream_bad, busy1, busy_dn);
    check_eq("pad_taps",    taps, 144);
    check_eq("pad_windows", wf_n, 16);
    check_eq("pad_done_c",  done_c, 146);
    check_eq("pad_stream",  stream_bad, 0);
    check_eq("pad_fr0",     rec_fr[0] + rec_fr[1] + rec_fr[2] + rec_fr[3] + rec_fr[6], 0);
    check_eq("pad_fr4",     rec_fr[4], 1);
    check_eq("pad_a4",      rec_addr[4], 'h200);
    check_eq("pad_a3",      rec_addr[3], 0);

    run_pass(2, 4, 4, 'h200, 1000, 0, -1, 0,
             taps, done_c, err_v, wf_n, hold_bad, stream_bad, busy1, busy_dn);
    check_eq("pad_k2_err",    err_v, 1);
    check_eq("pad_k2_done_c", done_c, 2);
    check_eq("pad_k2_taps",   taps, 0);
`endif

    run_pass(0, 5, 5, 'h100, 1000, 0, -1, 0,
             taps, done_c, err_v, wf_n, hold_bad, stream_bad, busy1, busy_dn);
    check_eq("k0_err",    err_v, 1);
    check_eq("k0_done_c", done_c, 2);
    check_eq("k0_taps",   taps, 0);
    check_eq("k0_busy_c1", busy1, 1);

    run_pass(6, 5, 8, 'h100, 1000, 0, -1, 0,
             taps, done_c, err_v, wf_n, hold_bad, stream_bad, busy1, busy_dn);
    check_eq("k6_err",    err_v, 1);
    check_eq("k6_done_c", done_c, 2);
    check_eq("k6_taps",   taps, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_window_scheduler.md
# conv_window_scheduler

Sequencer for one convolution layer pass. Walks every output pixel and every kernel tap, and for each tap issues one paired read: a weight RAM address and a feature-map RAM address. It emits window-boundary flags so the downstream MAC/accumulator can clear and dump its partial sums. It sits between the layer control FSM (start/done) and the weight RAM, feature RAM and MAC array, and replaces per-RAM free-running address counters with one coordinated scheduler.

## Interface
- `ADDR_W`, 12: feature RAM address width.
- `DIM_W`, 6: width of the image height/width fields (maximum 63).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle pulse; sampled only in IDLE.
- `kernel_size`  in  3  K, valid range 1..7; latched on start.
- `img_width`  in  DIM_W  W; latched on start.
- `img_height`  in  DIM_W  H; latched on start.
- `feat_base`  in  ADDR_W  feature map base address; latched on start.
- `mac_ready`  in  1  MAC can accept a tap this cycle.
- `addr_RAM_weight`  out  6  weight address, equal to ky*K+kx.
- `read_RAM_weight`  out  1  weight read strobe.
- `addr_RAM_feat`  out  ADDR_W  feature address.
- `read_RAM_feat`  out  1  feature read strobe.
- `win_first` / `win_last`  out  1  asserted with tap (0,0) / tap (K-1,K-1) of each window.
- `busy`  out  1  pass in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`; configuration rejected.

## Operation
- FSM states:
  - IDLE: `start` → CHECK.
  - CHECK: invalid → FIN with `err` = 1; valid → RUN.
  - RUN: issuing taps; after the last tap is accepted → FIN.
  - FIN: pulse `done`, then → IDLE.
- Counters: `kx` is innermost, then `ky`, then `ox`, then `oy`. Each counter wraps to 0 and carries into the next one out.
- Output size without padding: OW = W-K+1, OH = H-K+1.
- Feature address: `feat_base + (oy+ky)*W + (ox+kx)`. Computed at ADDR_W bits; overflow wraps modulo 2^ADDR_W.
- Invalid configuration (no padding build): K = 0, K > 7, K > W, or K > H.
- A tap is accepted in a RUN cycle where `mac_ready` = 1. On accept:
  - strobes are high with the addresses of the current tap;
  - counters advance.
- When `mac_ready` = 0 in RUN:
  - both strobes low;
  - counters and addresses hold.
- `start` while `busy` is ignored; `busy` and `done` are unaffected.
- Configuration inputs are ignored outside the start cycle.
- K = 1: every tap is both `win_first` and `win_last`.

## Timing
- Reset values:
  - state IDLE, all counters 0;
  - `addr_RAM_weight`, `addr_RAM_feat` = 0;
  - all strobes, flags, `busy`, `done`, `err` = 0.
- All outputs are registered.
- `start` at cycle 0:
  - cycle 1: CHECK, `busy` = 1;
  - cycle 2: first tap on outputs, earliest.
- With no stalls, exactly OH*OW*K*K consecutive strobe cycles.
- `done` rises the cycle after the last tap. `busy` falls in the same cycle `done` is high.
- Error path: `done` = `err` = 1 in cycle 2; no strobe is ever asserted.
- `rst` in any state aborts the pass within one cycle. All outputs return to reset values, with no `done`.
- Next `start` is accepted the cycle after `done`.

## Configuration
- Macro `CONV_PAD_EN` compiled in: "same" zero padding.
  - P = K/2; OW = W, OH = H.
  - Feature coordinates: row = oy+ky-P, col = ox+kx-P.
  - A tap outside [0,H)x[0,W) still counts as an accepted tap: `read_RAM_weight` = 1, `read_RAM_feat` = 0, `addr_RAM_feat` = 0.
  - Even K is also invalid.
- Macro not compiled in: no padding; all taps in range; formulas as in Operation.

## Test plan
- K=3, W=H=5, base=0x100, `mac_ready` = 1 → 81 strobe cycles in 9 windows.
  - Window 0 feature addresses: 0x100, 0x101, 0x102, 0x105, ..., 0x10C.
  - Window 1 starts at 0x101.
  - `done` at cycle 83.
- Same configuration, `mac_ready` low for 4 cycles at tap 10 → addresses hold; no strobes during the stall; `done` at cycle 87.
- K=0; and separately K=6 with W=5 → `done` and `err` in cycle 2; zero strobes.
- `start` reasserted mid-pass → ignored; tap count stays 81.
- `rst` at tap 40, then immediate restart → outputs zero the next cycle; the new pass begins at tap (0,0) with the base address.
- With `CONV_PAD_EN`, K=3, W=H=4 → 16 windows and 144 weight strobes.
  - Window 0: taps 0, 1, 2, 3, 6 are pad taps with `read_RAM_feat` = 0.
  - Tap 4 reads `feat_base`.
- With `CONV_PAD_EN`, K=2 → `err` = 1.
